// File: rtl/arb4_pkg.sv
// Shared types and helpers for the four-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Round-robin successor: (idx + 1) mod NUM_REQ, wrap comes from the width.
  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
    return idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Rotated priority scan: first asserted req starting at ptr, wrapping mod 4.
// Latency: purely combinational.
// Backpressure: none; result is only consumed when the arbiter is idle.
module rr_pick4
  import arb4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  // Scan from the farthest offset down so the nearest hit to ptr wins last.
  always_comb begin
    logic [IDX_W-1:0] cand;
    any  = 1'b0;
    idx  = ptr;
    cand = ptr;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand = ptr + off[IDX_W-1:0];
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter4_enc.sv
// Four-requester round-robin arbiter with registered encoded grant (idx + valid).
// Latency: req sampled -> gnt_valid one edge later; >=1 idle cycle between owners.
// Backpressure: owner holds req for its whole transaction; en only gates new grants.
module rr_arbiter4_enc
  import arb4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  localparam int CW = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic               gnt_valid,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_timeout
);

  localparam logic [CW-1:0] HOLD_SAT = '1;

  state_t           state_q, state_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_timeout_q, gnt_timeout_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             hold_expired;

  rr_pick4 u_pick (
    .req (req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == CW'(MAX_HOLD));

  // Next-state: arbitrate in IDLE, release on owner drop first, then on timeout.
  always_comb begin
    state_d       = state_q;
    gnt_valid_d   = gnt_valid_q;
    gnt_idx_d     = gnt_idx_q;
    gnt_timeout_d = 1'b0;
    ptr_d         = ptr_q;
    hold_cnt_d    = hold_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (en && pick_any) begin
          state_d     = GRANT;
          gnt_valid_d = 1'b1;
          gnt_idx_d   = pick_idx;
          hold_cnt_d  = CW'(1);
        end
      end
      GRANT: begin
        if (!req[gnt_idx_q] || hold_expired) begin
          // An owner drop wins over a coincident timeout, so no pulse then.
          state_d       = IDLE;
          gnt_valid_d   = 1'b0;
          ptr_d         = next_ptr(gnt_idx_q);
          gnt_timeout_d = req[gnt_idx_q];
        end else if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + CW'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      gnt_valid_q   <= 1'b0;
      gnt_idx_q     <= '0;
      gnt_timeout_q <= 1'b0;
      ptr_q         <= '0;
      hold_cnt_q    <= '0;
    end else begin
      state_q       <= state_d;
      gnt_valid_q   <= gnt_valid_d;
      gnt_idx_q     <= gnt_idx_d;
      gnt_timeout_q <= gnt_timeout_d;
      ptr_q         <= ptr_d;
      hold_cnt_q    <= hold_cnt_d;
    end
  end

  assign gnt_valid   = gnt_valid_q;
  assign gnt_idx     = gnt_idx_q;
  assign gnt_timeout = gnt_timeout_q;

endmodule

// File: doc/rr_arbiter4_enc.md
Name: rr_arbiter4_enc

Overview:
- Four-requester round-robin arbiter that emits a registered, encoded grant (2-bit index plus valid).
- Sits directly upstream of the 2-to-4 enabled decoder:
  - gnt_valid drives the decoder's enable.
  - gnt_idx[1] drives the decoder's i0 (MSB).
  - gnt_idx[0] drives the decoder's i1 (LSB).
- The decoder outputs y0..y3 therefore form the one-hot grant bus.
- The arbiter guarantees break-before-make: the one-hot bus is all-zero for at least one cycle between owners.

Parameters:
- MAX_HOLD, 8, maximum consecutive grant cycles per owner before forced release; 0 disables the timeout.
- CW, $clog2(MAX_HOLD+1) (minimum 1), hold-counter width; derived, not overridden.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  arbitration enable; gates new grants only.
- req  input  4  request lines; req[k] is held high by requester k for the whole transaction.
- gnt_valid  output  1  grant active; drives the decoder enable.
- gnt_idx  output  2  index of the current owner; held stable while gnt_valid=1.
- gnt_timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Clock is clk, reset is rst. All state and all outputs are registered.
- Reset (sampled at a clk edge):
  - state=IDLE, gnt_valid=0, gnt_idx=2'b00, gnt_timeout=0, ptr=2'b00, hold_cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0: winner = first k with req[k]=1, scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next cycle: state=GRANT, gnt_valid=1, gnt_idx=winner, hold_cnt=1.
  - Latency: req sampled high -> gnt_valid high on the next edge (1 cycle).
  - If en=0 or req=0: remain in IDLE, outputs unchanged (gnt_valid=0).
- GRANT, evaluated each cycle in this priority order:
  1. req[gnt_idx]=0 -> normal release. Next cycle: gnt_valid=0, ptr=gnt_idx+1 (3 wraps to 0), state=IDLE, gnt_timeout=0.
  2. MAX_HOLD!=0 and hold_cnt==MAX_HOLD -> forced release. Same as normal release, plus gnt_timeout=1 for exactly that one cycle.
  3. Otherwise stay in GRANT, hold_cnt+1; gnt_idx and gnt_valid unchanged.
- After any release, IDLE lasts at least one cycle, so the decoder outputs are all-zero for at least 1 cycle. No back-to-back grants.
- Requests from other lines while in GRANT are ignored; they are arbitrated in the next IDLE cycle.
- en=0 while in GRANT has no effect on the current grant; it only blocks the next one.
- Simultaneous owner-drop and timeout in the same cycle: treated as a normal release, gnt_timeout stays 0.
- With MAX_HOLD=0 the hold counter saturates at its maximum value and never forces a release.
- rst asserted mid-grant: on the next edge gnt_valid=0 and ptr=0; any partial hold count is discarded.
- gnt_idx retains its last value while gnt_valid=0. Consumers must qualify it with gnt_valid.

Decomposition:
- Package arb4_pkg holds:
  - NUM_REQ=4 and IDX_W=2.
  - Enumerated state type {IDLE, GRANT}.
  - Function next_ptr(idx) implementing (idx+1) mod 4.
- One combinational sub-module, rr_pick4:
  - Inputs: req[3:0], ptr[1:0].
  - Outputs: any, idx[1:0].
  - Implements the rotated priority scan.
- The top module holds the FSM, the hold counter, ptr, and the output registers.
- The decoder is instantiated by the parent, not inside this block.

Test Plan:
- Reset release, req=4'b0000 for 5 cycles -> gnt_valid=0, gnt_idx=0, gnt_timeout=0 throughout.
- Reset, then req=4'b1010 held 3 cycles and dropped:
  - Grant to idx=1 one cycle after req is sampled.
  - After req[1] drops, gnt_valid=0 for 1 cycle.
  - Next grant goes to idx=3 (ptr=2); decoder sees y1 then y3, never overlapping.
- All four requesting continuously, each dropping its req 2 cycles after being granted -> grant order 0,1,2,3,0, each grant separated by one gnt_valid=0 cycle; ptr wraps 3->0.
- MAX_HOLD=8, req[2] held indefinitely:
  - gnt_valid=1 for exactly 8 cycles with gnt_idx=2.
  - Then gnt_valid=0 and gnt_timeout=1 for one cycle.
  - Then idx 2 is re-granted only if no other requester exists.
- req[0] dropped on the same cycle hold_cnt==MAX_HOLD -> release with gnt_timeout=0. Separately, assert rst during GRANT with idx=3 -> next cycle gnt_valid=0, ptr=0, and with req=4'b1001 the next grant is idx=0.
- en=0 with req=4'b0100 -> no grant. Deassert en while idx=2 is granted -> grant persists until req[2] drops; then no new grant until en=1.
